// File: rtl/imm_packer.sv
// imm_packer: packs opcode, register, funct3 and immediate fields into RV32I I/S/B/J
// instruction words. Two-stage valid/ready pipeline with an immediate range check and
// a saturating count of error words delivered downstream.
module imm_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  localparam logic [1:0] FmtI = 2'b00;
  localparam logic [1:0] FmtS = 2'b01;
  localparam logic [1:0] FmtB = 2'b10;
  localparam logic [1:0] FmtJ = 2'b11;

  // Stage 1: registered request. Only imm[20:0] is needed to pack any format;
  // the upper bits only matter for the range check, which is done on entry.
  logic        v1_q;
  logic [1:0]  fmt_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [20:0] imm_q;
  logic        err1_q;

  // Stage 2: registered packed word.
  logic        v2_q;
  logic [31:0] instr_q;
  logic        err2_q;
  logic [15:0] cnt_q;

  logic        adv1;
  logic        adv2;
  logic        in_err;
  logic [31:0] packed_word;

  // Pipeline advance conditions; in_ready depends on out_ready but never on in_*.
  always_comb begin
    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  // Encodability: bits above the format's sign bit must replicate it, and
  // branch/jump offsets must be even.
  always_comb begin
    in_err = 1'b0;
    unique case (in_fmt)
      FmtI, FmtS: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FmtB:       in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      FmtJ:       in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:    in_err = 1'b0;
    endcase
  end

  // Stage 1 register: capture the request and its error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      fmt_q    <= 2'b00;
      opcode_q <= 7'b0;
      funct3_q <= 3'b0;
      rd_q     <= 5'b0;
      rs1_q    <= 5'b0;
      rs2_q    <= 5'b0;
      imm_q    <= 21'b0;
      err1_q   <= 1'b0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        fmt_q    <= in_fmt;
        opcode_q <= in_opcode;
        funct3_q <= in_funct3;
        rd_q     <= in_rd;
        rs1_q    <= in_rs1;
        rs2_q    <= in_rs2;
        imm_q    <= in_imm[20:0];
        err1_q   <= in_err;
      end
    end
  end

  // Field placement from the stage-1 registers, inverse of the core's decoder.
  always_comb begin
    packed_word = 32'b0;
    unique case (fmt_q)
      FmtI: packed_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
      FmtS: packed_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
      FmtB: packed_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                           imm_q[4:1], imm_q[11], opcode_q};
      FmtJ: packed_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
      default: packed_word = 32'b0;
    endcase
  end

  // Stage 2 register: holds the word stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v2_q    <= 1'b0;
      instr_q <= 32'b0;
      err2_q  <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        instr_q <= packed_word;
        err2_q  <= err1_q;
      end
    end
  end

  // Saturating count of error words actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 16'b0;
    end else if (v2_q && out_ready && err2_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_valid = v2_q;
  assign out_instr = instr_q;
  assign out_err   = err2_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Testbench for imm_packer: randomized and directed stimulus, scoreboard queue
// filled on accept, drained by an independent output monitor.
module tb_imm_packer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  imm_packer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          imm;
    logic [1:0]  fmt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   acc_cnt = 0;
  int   ready_mode = 1;  // 0 hold low, 1 hold high, 2 random
  bit   bp_done;
  int   bounds[14] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                       1048574, 1048576, -1048576, -1048578, 1, -1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  function automatic int unsigned fld(input int unsigned u, input int hi, input int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference word built arithmetically from the RV32I field tables.
  function automatic logic [31:0] model_word(input int unsigned f, input int unsigned op,
                                             input int unsigned f3, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int imm);
    int unsigned u = imm;
    int unsigned w;
    case (f)
      0: w = (fld(u, 11, 0) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7);
      1: w = (fld(u, 11, 5) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
             + (fld(u, 4, 0) << 7);
      2: w = (fld(u, 12, 12) << 31) + (fld(u, 10, 5) << 25) + (rs2 << 20) + (rs1 << 15)
             + (f3 << 12) + (fld(u, 4, 1) << 8) + (fld(u, 11, 11) << 7);
      default: w = (fld(u, 20, 20) << 31) + (fld(u, 10, 1) << 21) + (fld(u, 11, 11) << 20)
                   + (fld(u, 19, 12) << 12) + (rd << 7);
    endcase
    return w + op;
  endfunction

  function automatic logic model_err(input int unsigned f, input int imm);
    case (f)
      0, 1: return (imm < -2048) || (imm > 2047);
      2: return (imm < -4096) || (imm > 4095) || (imm % 2 != 0);
      default: return (imm < -1048576) || (imm > 1048575) || (imm % 2 != 0);
    endcase
  endfunction

  // Sign-extended immediate recovered the way the core's decoder would.
  function automatic int decode(input logic [31:0] w, input logic [1:0] f);
    int v;
    case (f)
      2'b00: v = $signed(w) >>> 20;
      2'b01: v = (($signed(w) >>> 25) * 32) + int'({27'b0, w[11:7]});
      2'b10: v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'({26'b0, w[30:25]}) * 32
                 + int'({28'b0, w[11:8]}) * 2;
      default: v = (w[31] ? -1048576 : 0) + int'({24'b0, w[19:12]}) * 4096
                   + (w[20] ? 2048 : 0) + int'({22'b0, w[30:21]}) * 2;
    endcase
    return v;
  endfunction

  // Consumer ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Accept monitor: every handshake pushes the reference response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.instr = model_word(in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
        e.err   = model_err(in_fmt, in_imm);
        e.imm   = in_imm;
        e.fmt   = in_fmt;
        sb.push_back(e);
        acc_cnt++;
      end
    end
  end

  // Output monitor: compares delivered words, stall stability and err_count.
  initial begin
    exp_t        e;
    logic [15:0] mcnt = 16'd0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_instr = 32'b0;
    logic        prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mcnt = 16'd0;
        prev_stall = 1'b0;
      end else begin
        check(err_count == mcnt, "err_count", {16'b0, err_count}, {16'b0, mcnt});
        if (prev_stall) begin
          check(out_valid == 1'b1, "stall_valid", {31'b0, out_valid}, 32'd1);
          check(out_instr == prev_instr, "stall_instr", out_instr, prev_instr);
          check(out_err == prev_err, "stall_err", {31'b0, out_err}, {31'b0, prev_err});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_word", out_instr, 32'b0);
          end else begin
            e = sb.pop_front();
            check(out_instr == e.instr, "instr", out_instr, e.instr);
            check(out_err == e.err, "err", {31'b0, out_err}, {31'b0, e.err});
            if (!e.err)
              check(decode(out_instr, e.fmt) == e.imm, "roundtrip",
                    decode(out_instr, e.fmt), e.imm);
            if (e.err && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_instr = out_instr;
        prev_err   = out_err;
      end
    end
  end

  // Present one request; returns just after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    in_valid = 1'b1;
    in_fmt = f; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check(1'b0, "accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    int imm;
    case ($urandom_range(0, 3))
      0: imm = int'($urandom_range(0, 4095)) - 2048;
      1: imm = $urandom;
      2: imm = (int'($urandom_range(0, 2097151)) - 1048576) & -2;
      default: imm = bounds[$urandom_range(0, 13)];
    endcase
    send(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), imm);
  endtask

  // Directed request with latency and exact-word check; pipeline must be empty.
  task automatic send_expect(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             input logic [31:0] exp_instr, input logic exp_err,
                             input string name);
    send(f, op, f3, rd, rs1, rs2, imm);
    @(negedge clk);
    check(out_valid == 1'b0, {name, "_lat_early"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check(out_valid == 1'b1, {name, "_lat"}, {31'b0, out_valid}, 32'd1);
    check(out_instr == exp_instr, {name, "_word"}, out_instr, exp_instr);
    check(out_err == exp_err, {name, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(sb.size() == 0, "drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_fmt = 2'b00; in_opcode = 7'b0; in_funct3 = 3'b0;
    in_rd = 5'b0; in_rs1 = 5'b0; in_rs2 = 5'b0; in_imm = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check(out_valid == 1'b0, "rst_valid", {31'b0, out_valid}, 32'd0);
    check(out_instr == 32'b0, "rst_instr", out_instr, 32'd0);
    check(out_err == 1'b0, "rst_err", {31'b0, out_err}, 32'd0);
    check(err_count == 16'd0, "rst_count", {16'b0, err_count}, 32'd0);
    check(in_ready == 1'b1, "rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    send_expect(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, "i");
    send_expect(2'b01, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0, "s");
    send_expect(2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, "b");
    send_expect(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b0, "j");
    send_expect(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h801, 32'h001000EF, 1'b1, "j_odd");
    check(err_count == 16'd1, "count_after_j", {16'b0, err_count}, 32'd1);
    send_expect(2'b00, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048, 32'h80000013, 1'b1, "i_range");
    check(err_count == 16'd2, "count_after_range", {16'b0, err_count}, 32'd2);

    // Back-pressure: five words against a stalled consumer.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base = acc_cnt;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
        bp_done = 1'b1;
      end
    join_none
    repeat (4) @(negedge clk);
    check(acc_cnt - base == 2, "bp_accepts", acc_cnt - base, 32'd2);
    check(in_ready == 1'b0, "bp_ready", {31'b0, in_ready}, 32'd0);
    check(out_valid == 1'b1, "bp_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    ready_mode = 1;
    n = 0;
    while (!bp_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(bp_done, "bp_done", {31'b0, bp_done}, 32'd1);
    drain();
    check(acc_cnt - base == 5, "bp_total", acc_cnt - base, 32'd5);

    // Random traffic under random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) send_rand();
    ready_mode = 1;
    drain();

    // Reset with both stages full.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base = acc_cnt;
    fork
      begin
        send_rand();
        send_rand();
      end
    join_none
    n = 0;
    while (acc_cnt - base < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(acc_cnt - base == 2, "full_accepts", acc_cnt - base, 32'd2);
    @(posedge clk);
    #1;
    check(in_ready == 1'b0, "full_ready", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check(out_valid == 1'b0, "mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check(err_count == 16'd0, "mid_rst_count", {16'b0, err_count}, 32'd0);
    check(in_ready == 1'b1, "mid_rst_ready", {31'b0, in_ready}, 32'd1);
    ready_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "no_stale", {31'b0, out_valid}, 32'd0);

    // Saturation of the error counter.
    for (int i = 0; i < 65540; i++) send(2'b00, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    drain();
    check(err_count == 16'hFFFF, "count_saturate", {16'b0, err_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imm_packer.md
# imm_packer

Instruction assembler for the single-cycle RISC-V core's test and bootstrap path. It packs opcode, register, funct3 and immediate fields into a 32-bit RV32I instruction word for I, S, B and J formats, performing the inverse of the core's immediate extraction. It checks that the immediate is encodable, streams words out over a valid/ready interface through a 2-stage pipeline, and counts encoding errors. It sits between the program loader and the instruction-memory write port.

## Interface
- No parameters. All widths are fixed by RV32I.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  2  00 I, 01 S, 10 B, 11 J
- in_opcode  in  7  copied to instr[6:0]
- in_funct3  in  3  copied to instr[14:12] (I/S/B only)
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  32  signed byte-offset immediate
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  packed instruction
- out_err  out  1  immediate not encodable for in_fmt
- err_count  out  16  saturating count of words delivered with out_err=1

## Operation
- Field placement:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd
  - [6:0]=opcode in all formats. Fields not used by a format are ignored.
- Encodability, which sets err:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - On error the word is still packed from the truncated bits, with out_err=1. The word is never dropped.
- Stage 1 registers the request and computes err. Stage 2 registers the packed word and err.
- Invariant: for every word with out_err=0, sign-extending the immediate back out of out_instr using the same format yields in_imm exactly.
- err_count increments when out_valid && out_ready && out_err, and saturates at 0xFFFF.

## Timing
- Reset (reset_n=0 at a clock edge):
  - both stage valids clear, so out_valid=0
  - out_instr=0, out_err=0, err_count=0
  - in_ready=1 in the first cycle after reset
  - any in-flight words are discarded
- Stage 2 advances when !v2 || out_ready. Stage 1 advances when !v1 || (stage 2 advancing).
- in_ready = !v1 || stage-2 advancing. It is combinational from out_ready; there is no combinational path from in_* to out_*.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1, if out_ready was held 1.
- Throughput: 1 word per cycle with out_ready=1.
- Back-pressure:
  - out_instr and out_err are held stable while out_valid && !out_ready.
  - With out_ready=0 the block holds at most 2 words, then in_ready=0.
- Simultaneous accept and deliver in the same cycle with both stages full: both stages shift and the new word enters stage 1.

## Test plan
- I-format: fmt=00, opcode=0x13, funct3=0, rd=1, rs1=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, out_err=0, out_valid two edges after accept.
- S/B-format:
  - fmt=01, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423
  - fmt=10, opcode=0x63, rs1=rs2=0, imm=0xFFFFFFFC -> 0xFE000EE3
- J-format: fmt=11, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF, err=0. Repeat with imm=0x801 -> out_err=1, err_count=1.
- Range error: fmt=00, imm=2048 -> out_err=1, out_instr[31:20]=0x800. 65540 such words -> err_count=0xFFFF.
- Back-pressure: stream 5 words with out_ready low for 4 cycles ->
  - in_ready=0 after 2 accepts
  - out_instr stable while stalled
  - all 5 words delivered in order with no duplicates
- Reset mid-stream: assert reset_n=0 with both stages full -> out_valid=0 next cycle, err_count=0, in_ready=1, no stale word emitted afterward.
